cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 9 +
 rtl/cdb_queue.sv | 47 ++++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter slice: ROB id width,
// per-producer queue depth and broadcast data width.
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH_BIT   = 4;
    localparam int CDB_QUEUE_DEPTH = 2;
    localparam int DATA_W          = 32;

endpackage

// File: rtl/cdb_queue.sv
// Two-entry FIFO holding {rob_id, value} for one CDB producer.
// Ports: clk_in, flush (sync clear), push/pop strobes, push data,
// head data (valid when count != 0), count (0..2).
module cdb_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int ID_W = ROB_WIDTH_BIT
) (
    input  logic              clk_in,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [ID_W-1:0]   push_rob_id,
    input  logic [DATA_W-1:0] push_value,
    output logic [ID_W-1:0]   head_rob_id,
    output logic [DATA_W-1:0] head_value,
    output logic [1:0]        count
);

    logic [ID_W-1:0]   id_mem  [CDB_QUEUE_DEPTH];
    logic [DATA_W-1:0] val_mem [CDB_QUEUE_DEPTH];
    logic              head;
    logic              tail;

    assign head_rob_id = id_mem[head];
    assign head_value  = val_mem[head];

    // Storage is not reset; only the pointers and count define contents.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                id_mem[tail]  <= push_rob_id;
                val_mem[tail] <= push_value;
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining NUM_REQ producer queues onto one
// registered CDB. Ports: clk_in, rst_in, rdy_in (pause), clear (flush),
// req_valid/req_rob_id/req_value/req_ready per producer, cdb_* broadcast,
// busy (any queue occupied or broadcast present).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ      = 3,
    parameter  int ROB_SIZE_BIT = ROB_WIDTH_BIT,
    localparam int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ROB_SIZE_BIT-1:0] req_rob_id,
    input  logic [NUM_REQ*DATA_W-1:0]    req_value,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         cdb_valid,
    output logic [ROB_SIZE_BIT-1:0]      cdb_rob_id,
    output logic [DATA_W-1:0]            cdb_value,
    output logic [SRC_W-1:0]             cdb_src,
    output logic                         busy
);

    // Returns {found, index}: first candidate after 'from', wrapping.
    // Scanning far-to-near lets the nearest candidate overwrite the rest.
    function automatic logic [SRC_W:0] rr_pick(
        input logic [NUM_REQ-1:0] cand,
        input logic [SRC_W-1:0]   from
    );
        logic [SRC_W:0] r;
        int             idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(from) + k) % NUM_REQ;
            if (cand[idx]) begin
                r = {1'b1, SRC_W'(idx)};
            end
        end
        return r;
    endfunction

    logic                    flush;
    logic [NUM_REQ-1:0]      nonempty;
    logic [NUM_REQ-1:0]      push;
    logic [NUM_REQ-1:0]      pop;
    logic [1:0]              cnt     [NUM_REQ];
    logic [ROB_SIZE_BIT-1:0] head_id [NUM_REQ];
    logic [DATA_W-1:0]       head_val[NUM_REQ];
    logic [SRC_W-1:0]        last;
    logic [SRC_W:0]          pick;
    logic                    found;
    logic [SRC_W-1:0]        win;
    logic [ROB_SIZE_BIT-1:0] sel_id;
    logic [DATA_W-1:0]       sel_val;

    assign flush = rst_in || clear;
    assign pick  = rr_pick(nonempty, last);
    assign found = pick[SRC_W];
    assign win   = pick[SRC_W-1:0];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_q
        assign nonempty[g]  = cnt[g] != 2'd0;
        // Ready uses only the registered count, never a same-cycle pop.
        assign req_ready[g] = rdy_in && !rst_in && cnt[g] != 2'd2;
        assign push[g]      = req_valid[g] && req_ready[g];
        assign pop[g]       = rdy_in && found && win == SRC_W'(g);

        cdb_queue #(
            .ID_W(ROB_SIZE_BIT)
        ) u_queue (
            .clk_in     (clk_in),
            .flush      (flush),
            .push       (push[g]),
            .pop        (pop[g]),
            .push_rob_id(req_rob_id[g*ROB_SIZE_BIT +: ROB_SIZE_BIT]),
            .push_value (req_value[g*DATA_W +: DATA_W]),
            .head_rob_id(head_id[g]),
            .head_value (head_val[g]),
            .count      (cnt[g])
        );
    end

    always_comb begin
        sel_id  = '0;
        sel_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == SRC_W'(i)) begin
                sel_id  = head_id[i];
                sel_val = head_val[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (flush) begin
            last       <= SRC_W'(NUM_REQ - 1);
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
        end else if (rdy_in) begin
            cdb_valid <= found;
            if (found) begin
                last       <= win;
                cdb_rob_id <= sel_id;
                cdb_value  <= sel_val;
                cdb_src    <= win;
            end
        end
    end

    assign busy = (|nonempty) || cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-producer reference queues
// are filled on accepted handshakes and drained on modelled grants.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int IW = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   val;
    } ent_t;

    logic            clk;
    logic            rst;
    logic            rdy;
    logic            clr;
    logic [N-1:0]    valid;
    logic [N*IW-1:0] ids;
    logic [N*32-1:0] vals;
    logic [N-1:0]    ready;
    logic            cdb_valid;
    logic [IW-1:0]   cdb_rob_id;
    logic [31:0]     cdb_value;
    logic [1:0]      cdb_src;
    logic            busy;

    cdb_arbiter #(
        .NUM_REQ     (N),
        .ROB_SIZE_BIT(IW)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .rdy_in    (rdy),
        .clear     (clr),
        .req_valid (valid),
        .req_rob_id(ids),
        .req_value (vals),
        .req_ready (ready),
        .cdb_valid (cdb_valid),
        .cdb_rob_id(cdb_rob_id),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t src[N][$];
    ent_t mq[N][$];
    int   mlast;
    logic mv;
    logic [1:0] msrc;
    logic [IW-1:0] mid;
    logic [31:0] mval;
    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = rdy && !rst && mq[i].size() != 2;
        end
        return r;
    endfunction

    function automatic logic exp_busy();
        logic b;
        b = mv;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drive();
        valid = '0;
        ids   = '0;
        vals  = '0;
        for (int i = 0; i < N; i++) begin
            if (src[i].size() > 0) begin
                valid[i]          = 1'b1;
                ids[i*IW +: IW]   = src[i][0].id;
                vals[i*32 +: 32]  = src[i][0].val;
            end
        end
    endtask

    task automatic model_step(input logic [N-1:0] acc);
        int   w;
        bit   found;
        ent_t e;
        if (rst || clr) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mlast = N - 1;
            mv = 0; msrc = 0; mid = 0; mval = 0;
        end else if (rdy) begin
            found = 0;
            w = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && mq[(mlast + k) % N].size() > 0) begin
                    found = 1;
                    w = (mlast + k) % N;
                end
            end
            if (found) begin
                e = mq[w].pop_front();
                mv = 1; msrc = 2'(w); mid = e.id; mval = e.val;
                mlast = w;
            end else begin
                mv = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) mq[i].push_back(src[i][0]);
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        drive();
        #1;
        check("req_ready", 64'(ready), 64'(exp_ready()));
        check("busy", 64'(busy), 64'(exp_busy()));
        acc = valid & exp_ready();
        @(posedge clk);
        model_step(acc);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src[i].pop_front());
        end
        @(negedge clk);
        check("cdb", 64'({cdb_valid, cdb_src, cdb_rob_id, cdb_value}),
              64'({mv, msrc, mid, mval}));
    endtask

    function automatic bit pending();
        bit p;
        p = mv;
        for (int i = 0; i < N; i++) begin
            if (src[i].size() > 0 || mq[i].size() > 0) p = 1;
        end
        return p;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (pending() && n < 80) begin
            tick();
            n++;
        end
        check("drain_budget", 64'(n < 80), 64'(1));
    endtask

    task automatic add(input int p, input int id);
        ent_t e;
        e.id  = IW'(id);
        e.val = $urandom;
        src[p].push_back(e);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mlast = N - 1;
        mv = 0; msrc = 0; mid = 0; mval = 0;
        rst = 1'b1; clr = 1'b0; rdy = 1'b1;
        valid = '0; ids = '0; vals = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // single producer, fixed payload
        tick();
        src[1].push_back('{id: 4'd5, val: 32'h1234});
        repeat (5) tick();

        // all producers every cycle
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < N; i++) add(i, i);
        end
        drain();

        // backpressure on producer 0
        for (int n = 0; n < 4; n++) begin
            add(1, 8 + n);
            add(2, 12 + n);
        end
        tick();
        add(0, 1); add(0, 2); add(0, 3);
        drain();

        // clear with full queues and id 7 offered
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < N; i++) add(i, 9 + i);
        end
        repeat (4) tick();
        for (int i = 0; i < N; i++) src[i].delete();
        add(2, 7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N; i++) src[i].delete();
        tick();
        tick();

        // pause while id 4 is on the bus
        add(0, 4); add(0, 5);
        add(1, 8); add(1, 9);
        add(2, 10); add(2, 11);
        repeat (2) tick();
        check("pause_id", 64'(cdb_rob_id), 64'(4));
        rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        drain();

        // wrap-around from last = 2 with queues 0 and 2 only
        clr = 1'b1;
        tick();
        clr = 1'b0;
        add(0, 1);
        add(2, 2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
